// File: rtl/exc_pkg.sv
// Shared definitions for the exception trap controller: FSM state encoding,
// cause codes, fixed handler vectors and the default ERET opcode.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_FLUSH        = 3'd1,
    ST_REDIRECT     = 3'd2,
    ST_HANDLER      = 3'd3,
    ST_RET_FLUSH    = 3'd4,
    ST_RET_REDIRECT = 3'd5,
    ST_HALT         = 3'd6
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_DIV0  = 2'd1;
  localparam logic [1:0] CAUSE_OVF   = 2'd2;
  localparam logic [1:0] CAUSE_OTHER = 2'd3;

  localparam logic [18:0] VEC_DIV0 = 19'h7fff0;
  localparam logic [18:0] VEC_OVF  = 19'h7fff1;

  localparam logic [4:0] ERET_OPC_DEF = 5'b11110;

endpackage

// File: rtl/exc_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous
// active-high reset. Only built when EXC_TRAP_COUNT_EN is defined.
`ifdef EXC_TRAP_COUNT_EN
module exc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/exc_trap_controller.sv
// Trap entry/exit sequencer sitting between the EX-stage exception unit and
// the fetch/hazard logic. Captures the faulting PC and cause, holds the
// younger-stage flushes for FLUSH_CYCLES cycles, redirects fetch to the
// handler, and returns to epc+1 on ERET. A fault inside the handler halts
// the core (double fault) until reset.
// Optional build macro EXC_TRAP_COUNT_EN adds a saturating exc_count output
// counting accepted trap entries.
module exc_trap_controller
  import exc_pkg::*;
#(
  parameter int                ADDR_W       = 19,
  parameter int                OPC_W        = 5,
  parameter logic [OPC_W-1:0]  ERET_OPC     = OPC_W'(ERET_OPC_DEF),
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [OPC_W-1:0]  ex_opcode,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_handler_addr,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              pc_redirect_valid,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic [ADDR_W-1:0] epc,
  output logic [1:0]        cause,
  output logic              in_handler,
  output logic              double_fault
`ifdef EXC_TRAP_COUNT_EN
  ,
  output logic [15:0]       exc_count
`endif
);

  // FLUSH_CYCLES is limited to 1..7, so three bits cover the down-counter.
  localparam int CNT_W = 3;

  state_t              state;
  logic [CNT_W-1:0]    flush_cnt;
  logic [ADDR_W-1:0]   vector;
  logic                trap_take;

  // Known vectors map to their dedicated cause; anything else is "other".
  function automatic logic [1:0] vec_to_cause(input logic [ADDR_W-1:0] vec);
    if (vec == ADDR_W'(VEC_DIV0)) begin
      return CAUSE_DIV0;
    end else if (vec == ADDR_W'(VEC_OVF)) begin
      return CAUSE_OVF;
    end else begin
      return CAUSE_OTHER;
    end
  endfunction

  // A new trap is accepted only from IDLE and only for a valid EX instruction.
  always_comb begin
    trap_take = (state == ST_IDLE) && ex_valid && exc_req;
  end

  // Trap sequencing FSM with registered flush/redirect/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      flush_cnt         <= '0;
      vector            <= '0;
      epc               <= '0;
      cause             <= CAUSE_NONE;
      flush_if_id       <= 1'b0;
      flush_id_ex       <= 1'b0;
      flush_ex_mem      <= 1'b0;
      pc_redirect_valid <= 1'b0;
      pc_redirect_addr  <= '0;
      in_handler        <= 1'b0;
      double_fault      <= 1'b0;
    end else begin
      pc_redirect_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (trap_take) begin
            state        <= ST_FLUSH;
            flush_cnt    <= CNT_W'(FLUSH_CYCLES - 1);
            epc          <= ex_pc;
            vector       <= exc_handler_addr;
            cause        <= vec_to_cause(exc_handler_addr);
            flush_if_id  <= 1'b1;
            flush_id_ex  <= 1'b1;
            flush_ex_mem <= 1'b1;
          end
        end
        // Instructions seen here are being squashed, so exc_req is ignored.
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state             <= ST_REDIRECT;
            flush_if_id       <= 1'b0;
            flush_id_ex       <= 1'b0;
            flush_ex_mem      <= 1'b0;
            pc_redirect_valid <= 1'b1;
            pc_redirect_addr  <= vector;
            in_handler        <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          state <= ST_HANDLER;
        end
        // An exception beats a simultaneous ERET: that is a double fault.
        ST_HANDLER: begin
          if (ex_valid && exc_req) begin
            state        <= ST_HALT;
            double_fault <= 1'b1;
            flush_if_id  <= 1'b1;
            flush_id_ex  <= 1'b1;
            flush_ex_mem <= 1'b1;
          end else if (ex_valid && (ex_opcode == ERET_OPC)) begin
            state        <= ST_RET_FLUSH;
            flush_if_id  <= 1'b1;
            flush_id_ex  <= 1'b1;
            flush_ex_mem <= 1'b0;
          end
        end
        // ERET itself retires, only the younger stages are flushed.
        ST_RET_FLUSH: begin
          state             <= ST_RET_REDIRECT;
          flush_if_id       <= 1'b0;
          flush_id_ex       <= 1'b0;
          pc_redirect_valid <= 1'b1;
          pc_redirect_addr  <= epc + ADDR_W'(1);
          in_handler        <= 1'b0;
          cause             <= CAUSE_NONE;
        end
        ST_RET_REDIRECT: begin
          state <= ST_IDLE;
        end
        // Absorbing: front end stays flushed until reset.
        ST_HALT: begin
          flush_ex_mem <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef EXC_TRAP_COUNT_EN
  exc_sat_counter #(
    .WIDTH (16)
  ) u_exc_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (trap_take),
    .clear (1'b0),
    .count (exc_count)
  );
`endif

endmodule

// File: tb/tb_exc_trap_controller.sv
// Directed bench for exc_trap_controller with a timeline-based reference
// model: each accepted event schedules the output frames it causes, and a
// compare process checks every output on every falling edge.
module tb_exc_trap_controller;

  localparam int         ADDR_W = 19;
  localparam int         OPC_W  = 5;
  localparam int         F      = 2;
  localparam logic [4:0] ERET   = 5'b11110;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ex_valid = 1'b0;
  logic [OPC_W-1:0]  ex_opcode = '0;
  logic [ADDR_W-1:0] ex_pc = '0;
  logic              exc_req = 1'b0;
  logic [ADDR_W-1:0] exc_handler_addr = '0;
  logic              flush_if_id, flush_id_ex, flush_ex_mem;
  logic              pc_redirect_valid;
  logic [ADDR_W-1:0] pc_redirect_addr, epc;
  logic [1:0]        cause;
  logic              in_handler, double_fault;
`ifdef EXC_TRAP_COUNT_EN
  logic [15:0]       exc_count;
`endif

  exc_trap_controller #(
    .ADDR_W       (ADDR_W),
    .OPC_W        (OPC_W),
    .ERET_OPC     (ERET),
    .FLUSH_CYCLES (F)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid          (ex_valid),
    .ex_opcode         (ex_opcode),
    .ex_pc             (ex_pc),
    .exc_req           (exc_req),
    .exc_handler_addr  (exc_handler_addr),
    .flush_if_id       (flush_if_id),
    .flush_id_ex       (flush_id_ex),
    .flush_ex_mem      (flush_ex_mem),
    .pc_redirect_valid (pc_redirect_valid),
    .pc_redirect_addr  (pc_redirect_addr),
    .epc               (epc),
    .cause             (cause),
    .in_handler        (in_handler),
    .double_fault      (double_fault)
`ifdef EXC_TRAP_COUNT_EN
    ,
    .exc_count         (exc_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // t counts edges since reset; "frame t" is what the outputs show after edge t.
  // busy_end is the last edge whose inputs are swallowed by a running sequence.
  int          t = 0;
  int          busy_end = 0;
  logic [18:0] m_epc = '0, m_addr = '0;
  logic [1:0]  m_cause = '0;
  logic        m_inh = 1'b0, m_df = 1'b0, m_rv = 1'b0;
  logic [2:0]  m_fl = '0;
  logic [15:0] m_cnt = '0;
  logic [2:0]  s_fl [int];
  logic [18:0] s_rd [int];
  bit          s_ret [int];

  function automatic logic [1:0] cause_for(input logic [18:0] v);
    return (v == 19'h7fff0) ? 2'd1 : (v == 19'h7fff1) ? 2'd2 : 2'd3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; busy_end = 0;
      m_epc = '0; m_addr = '0; m_cause = '0; m_inh = 1'b0; m_df = 1'b0;
      m_rv = 1'b0; m_fl = '0; m_cnt = '0;
      s_fl.delete(); s_rd.delete(); s_ret.delete();
    end else begin
      t++;
      if (!m_df && t > busy_end && ex_valid) begin
        if (!m_inh && exc_req) begin
          m_epc   = ex_pc;
          m_cause = cause_for(exc_handler_addr);
          for (int i = 0; i < F; i++) s_fl[t+i] = 3'b111;
          s_rd[t+F]  = exc_handler_addr;
          s_ret[t+F] = 1'b0;
          busy_end   = t + F + 1;
          if (m_cnt != 16'hffff) m_cnt++;
        end else if (m_inh && exc_req) begin
          m_df    = 1'b1;
          s_fl[t] = 3'b111;
        end else if (m_inh && ex_opcode == ERET) begin
          s_fl[t]    = 3'b110;
          s_rd[t+1]  = m_epc + 19'd1;
          s_ret[t+1] = 1'b1;
          busy_end   = t + 2;
        end
      end
      m_fl = m_df ? 3'b110 : 3'b000;
      m_rv = 1'b0;
      if (s_fl.exists(t)) m_fl = s_fl[t];
      if (s_rd.exists(t)) begin
        m_rv   = 1'b1;
        m_addr = s_rd[t];
        if (s_ret[t]) begin
          m_inh   = 1'b0;
          m_cause = 2'd0;
        end else begin
          m_inh = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    chk("flush_if_id", flush_if_id, m_fl[2]);
    chk("flush_id_ex", flush_id_ex, m_fl[1]);
    chk("flush_ex_mem", flush_ex_mem, m_fl[0]);
    chk("pc_redirect_valid", pc_redirect_valid, m_rv);
    chk("pc_redirect_addr", pc_redirect_addr, m_addr);
    chk("epc", epc, m_epc);
    chk("cause", cause, m_cause);
    chk("in_handler", in_handler, m_inh);
    chk("double_fault", double_fault, m_df);
`ifdef EXC_TRAP_COUNT_EN
    chk("exc_count", exc_count, m_cnt);
`endif
    chk("redirect_back_to_back", prev_rv & pc_redirect_valid, 1'b0);
    prev_rv = pc_redirect_valid;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [4:0] op, input logic [18:0] pc,
                      input logic req, input logic [18:0] vec);
    ex_valid = v; ex_opcode = op; ex_pc = pc; exc_req = req; exc_handler_addr = vec;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 5'd0, 19'h0, 1'b0, 19'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b000);
    chk("reset_epc", epc, 19'h0);
    chk("reset_redirect_addr", pc_redirect_addr, 19'h0);
    rst = 1'b0;

    // Masking: invalid exc_req and ERET in IDLE do nothing.
    step(1'b0, 5'd1, 19'h00055, 1'b1, 19'h7fff0);
    step(1'b1, ERET, 19'h00056, 1'b0, 19'h0);
    idle(2);
    chk("mask_flush", flush_if_id, 1'b0);
    chk("mask_epc", epc, 19'h0);

    // Divide-by-zero entry, second exc_req during FLUSH is ignored.
    step(1'b1, 5'd3, 19'h00120, 1'b1, 19'h7fff0);
    chk("div0_flush_all", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b111);
    chk("div0_epc", epc, 19'h00120);
    chk("div0_cause", cause, 2'd1);
    step(1'b1, 5'd3, 19'h00333, 1'b1, 19'h7fff1);
    chk("div0_flush_2nd", flush_if_id, 1'b1);
    chk("flush_ignore_epc", epc, 19'h00120);
    idle(1);
    chk("div0_redirect", pc_redirect_valid, 1'b1);
    chk("div0_vector", pc_redirect_addr, 19'h7fff0);
    chk("div0_in_handler", in_handler, 1'b1);
    chk("div0_flush_off", flush_if_id, 1'b0);
    idle(3);
    step(1'b1, ERET, 19'h7fff2, 1'b0, 19'h0);
    chk("div0_ret_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b110);
    idle(1);
    chk("div0_ret_addr", pc_redirect_addr, 19'h00121);
    chk("div0_ret_inh", in_handler, 1'b0);
    idle(2);

    // Overflow entry and return.
    step(1'b1, 5'd4, 19'h00200, 1'b1, 19'h7fff1);
    idle(4);
    chk("ovf_cause", cause, 2'd2);
    step(1'b1, ERET, 19'h7fff1, 1'b0, 19'h0);
    idle(1);
    chk("ovf_ret_valid", pc_redirect_valid, 1'b1);
    chk("ovf_ret_addr", pc_redirect_addr, 19'h00201);
    chk("ovf_ret_cause", cause, 2'd0);
    idle(2);

    // Wrap of epc+1, with a non-standard vector.
    step(1'b1, 5'd4, 19'h7ffff, 1'b1, 19'h01000);
    idle(4);
    chk("other_cause", cause, 2'd3);
    step(1'b1, ERET, 19'h01000, 1'b0, 19'h0);
    idle(1);
    chk("wrap_addr", pc_redirect_addr, 19'h00000);
    chk("wrap_epc_kept", epc, 19'h7ffff);
    idle(2);
`ifdef EXC_TRAP_COUNT_EN
    chk("count_three", exc_count, 16'd3);
`endif

    // Asynchronous reset in the middle of FLUSH.
    step(1'b1, 5'd4, 19'h00050, 1'b1, 19'h7fff0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b000);
    chk("midrst_epc", epc, 19'h0);
    chk("midrst_cause", cause, 2'd0);
`ifdef EXC_TRAP_COUNT_EN
    chk("midrst_count", exc_count, 16'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Double fault: exc_req and ERET together in the handler.
    step(1'b1, 5'd4, 19'h00400, 1'b1, 19'h7fff0);
    idle(4);
    step(1'b1, ERET, 19'h7fff3, 1'b1, 19'h7fff1);
    chk("df_set", double_fault, 1'b1);
    chk("df_flush_all", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b111);
    step(1'b1, ERET, 19'h7fff4, 1'b0, 19'h0);
    chk("df_halt_flush", {flush_if_id, flush_id_ex, flush_ex_mem}, 3'b110);
    chk("df_no_redirect", pc_redirect_valid, 1'b0);
    step(1'b1, 5'd5, 19'h7fff5, 1'b1, 19'h7fff0);
    step(1'b1, ERET, 19'h7fff6, 1'b0, 19'h0);
    idle(2);
    chk("df_sticky", double_fault, 1'b1);
    chk("df_epc_kept", epc, 19'h00400);
`ifdef EXC_TRAP_COUNT_EN
    chk("df_not_counted", exc_count, 16'd1);
`endif

    // Only reset leaves HALT.
    rst = 1'b1;
    #1;
    chk("halt_reset_df", double_fault, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
